gpr_sb_file: RTL and testbench

- Parametrised general-purpose register file for the pipelined datapath.
- Provides two combinational read ports, one synchronous write-back port, optional write-to-read bypass, and a post-read shifter on port B.
- Holds a per-register pending-write scoreboard that issue/decode uses for hazard stalls.
- Flags a sticky error when a write-back arrives with no matching reservation.

---
 rtl/gpr_sb_file.sv | 125 ++++++++++++
 tb/tb_gpr_sb_file.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_sb_file.sv
// General-purpose register file: two combinational read ports (B with a post-read
// shifter), one write-back port, optional forwarding, and a pending-write scoreboard.
module gpr_sb_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SHAMT_W  = 5,
  parameter int PEND_W   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_busy,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [SHAMT_W-1:0] rb_shamt,
  input  logic [1:0]        rb_mode,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_busy,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_full,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wb_err
);

  localparam int NREG = 2**ADDR_W;
  localparam int NRD  = 2;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {M_PASS = 2'b00, M_SLL = 2'b01, M_SRL = 2'b10, M_SRA = 2'b11} shmode_e;

  logic [NREG-1:0][DATA_W-1:0] rf_q, rf_d;
  logic [NREG-1:0][PEND_W-1:0] cnt_q, cnt_d;
  logic                        wb_err_q, wb_err_d;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // ---------------- scoreboard / write-back control ----------------
  logic              wr_ok, inc, dec, pair, orphan;
  logic [PEND_W-1:0] wr_cnt;

  assign wr_ok    = we & writable(wr_addr);
  assign wr_cnt   = cnt_q[wr_addr];
  assign rsv_full = (cnt_q[rsv_addr] == CNT_MAX);
  assign inc      = rsv_en & ~rsv_full & writable(rsv_addr);
  // Same-edge reserve + write-back of one register cancel, even from an idle counter.
  assign pair     = inc & wr_ok & (rsv_addr == wr_addr);
  assign dec      = wr_ok & ((wr_cnt != '0) | pair);
  assign orphan   = wr_ok & (wr_cnt == '0) & ~pair;

  always_comb begin
    cnt_d    = cnt_q;
    rf_d     = rf_q;
    wb_err_d = wb_err_q | orphan;
    if (!pair) begin
      if (inc) cnt_d[rsv_addr] = cnt_q[rsv_addr] + 1'b1;
      if (dec) cnt_d[wr_addr]  = cnt_q[wr_addr] - 1'b1;
    end
    if (wr_ok) rf_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q     <= '0;
      cnt_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      rf_q     <= rf_d;
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err = wb_err_q;

  // ---------------- read ports ----------------
  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_busy;

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic hit, fwd_dec;
    logic [PEND_W-1:0] cnt_eff;
    assign hit     = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p]);
    // A write-back retiring this cycle no longer blocks a forwarded read.
    assign fwd_dec = hit && (wr_cnt != '0);
    assign cnt_eff = cnt_q[rd_addr[p]] - PEND_W'(fwd_dec);
    assign rd_busy[p] = writable(rd_addr[p]) && (cnt_eff != '0);
    assign rd_data[p] = !writable(rd_addr[p]) ? '0 :
                        hit                   ? wr_data : rf_q[rd_addr[p]];
  end

  assign ra_data = rd_data[0];
  assign ra_busy = rd_busy[0];
  assign rb_busy = rd_busy[1];

  // ---------------- port B shifter ----------------
  logic [DATA_W-1:0] b_raw;
  logic              sh_big;

  assign b_raw  = rd_data[1];
  assign sh_big = ({1'b0, rb_shamt} >= (SHAMT_W+1)'(DATA_W));

  always_comb begin
    rb_data = b_raw;
    case (shmode_e'(rb_mode))
      M_PASS: rb_data = b_raw;
      M_SLL:  rb_data = sh_big ? '0 : (b_raw << rb_shamt);
      M_SRL:  rb_data = sh_big ? '0 : (b_raw >> rb_shamt);
      M_SRA:  rb_data = sh_big ? {DATA_W{b_raw[DATA_W-1]}}
                               : DATA_W'($signed(b_raw) >>> rb_shamt);
      default: rb_data = b_raw;
    endcase
  end

endmodule

// File: tb/tb_gpr_sb_file.sv
// Scoreboard bench for gpr_sb_file: expectations are queued with each stimulus
// cycle and popped against the DUT outputs on the following falling edge.
module tb_gpr_sb_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra_addr, rb_addr, rsv_addr, wr_addr, rb_shamt;
  logic [1:0]  rb_mode;
  logic [31:0] ra_data, rb_data, wr_data;
  logic        ra_busy, rb_busy, rsv_en, rsv_full, we, wb_err;

  gpr_sb_file dut (
    .clk(clk), .reset(reset),
    .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
    .rb_addr(rb_addr), .rb_shamt(rb_shamt), .rb_mode(rb_mode),
    .rb_data(rb_data), .rb_busy(rb_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_full(rsv_full),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RAD, K_RAB, K_RBD, K_RBB, K_FULL, K_ERR} kind_e;
  typedef struct { string tag; kind_e kind; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input kind_e k, input logic [31:0] v);
    sb.push_back('{tag, k, v});
  endtask

  // Settle on the falling edge, drain expectations, then step past the rising edge.
  task automatic cyc();
    exp_t e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RAD:   obs = ra_data;
        K_RAB:   obs = {31'b0, ra_busy};
        K_RBD:   obs = rb_data;
        K_RBB:   obs = {31'b0, rb_busy};
        K_FULL:  obs = {31'b0, rsv_full};
        default: obs = {31'b0, wb_err};
      endcase
      chk(e.tag, obs, e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rsv_en = 0; we = 0; reset = 0;
  endtask

  initial begin
    reset = 1; ra_addr = 0; rb_addr = 0; rb_shamt = 0; rb_mode = 0;
    rsv_en = 0; rsv_addr = 0; we = 0; wr_addr = 0; wr_data = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // Reset state on every address
    for (int a = 0; a < 32; a++) begin
      ra_addr = 5'(a); rb_addr = 5'(a); rb_mode = 2'b00;
      expect_v($sformatf("rst_ra%0d", a), K_RAD, 32'h0);
      expect_v($sformatf("rst_rb%0d", a), K_RBD, 32'h0);
      if (a % 8 == 0) begin
        expect_v("rst_rabusy", K_RAB, 0);
        expect_v("rst_rbbusy", K_RBB, 0);
        expect_v("rst_err", K_ERR, 0);
      end
      cyc();
    end

    // Reserve r5, write back three cycles later with forwarding
    ra_addr = 5; rsv_en = 1; rsv_addr = 5;
    expect_v("r5_c0_busy", K_RAB, 0);
    expect_v("r5_c0_full", K_FULL, 0);
    cyc();
    idle();
    expect_v("r5_c1_busy", K_RAB, 1); cyc();
    expect_v("r5_c2_busy", K_RAB, 1); cyc();
    we = 1; wr_addr = 5; wr_data = 32'h1234_5678;
    expect_v("r5_c3_data", K_RAD, 32'h1234_5678);
    expect_v("r5_c3_busy", K_RAB, 0);
    cyc();
    idle();
    expect_v("r5_c4_data", K_RAD, 32'h1234_5678);
    expect_v("r5_c4_busy", K_RAB, 0);
    expect_v("r5_c4_err", K_ERR, 0);
    cyc();

    // Saturate r7: three reservations accepted, fourth refused and counter holds
    rsv_en = 1; rsv_addr = 7; ra_addr = 7;
    for (int i = 0; i < 3; i++) begin
      expect_v($sformatf("r7_full%0d", i), K_FULL, 0);
      cyc();
    end
    expect_v("r7_full3", K_FULL, 1);
    cyc();
    idle();
    expect_v("r7_sat_busy", K_RAB, 1);
    expect_v("r7_sat_full", K_FULL, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      we = 1; wr_addr = 7; wr_data = 32'(100 + i);
      expect_v($sformatf("r7_wb%0d_busy", i), K_RAB, (i == 2) ? 32'd0 : 32'd1);
      expect_v($sformatf("r7_wb%0d_data", i), K_RAD, 32'(100 + i));
      cyc();
    end
    idle();
    expect_v("r7_end_busy", K_RAB, 0);
    expect_v("r7_end_full", K_FULL, 0);
    expect_v("r7_end_err", K_ERR, 0);
    expect_v("r7_end_data", K_RAD, 32'd102);
    cyc();

    // Paired reserve + write-back on an idle counter: no error, no residue
    rsv_en = 1; rsv_addr = 12; we = 1; wr_addr = 12; wr_data = 32'hABCD;
    cyc();
    idle(); ra_addr = 12;
    expect_v("pair_busy", K_RAB, 0);
    expect_v("pair_err", K_ERR, 0);
    expect_v("pair_data", K_RAD, 32'hABCD);
    cyc();

    // Orphan write-back to r9: data lands, error is sticky until reset
    ra_addr = 9; we = 1; wr_addr = 9; wr_data = 32'hCAFE_F00D;
    expect_v("orph_fwd", K_RAD, 32'hCAFE_F00D);
    expect_v("orph_err_pre", K_ERR, 0);
    cyc();
    idle();
    expect_v("orph_err", K_ERR, 1);
    expect_v("orph_data", K_RAD, 32'hCAFE_F00D);
    expect_v("orph_busy", K_RAB, 0);
    cyc();
    for (int i = 0; i < 9; i++) cyc();
    expect_v("orph_err_idle", K_ERR, 1);
    cyc();
    reset = 1;
    expect_v("orph_err_rstcyc", K_ERR, 1);
    cyc();
    reset = 0;
    expect_v("orph_err_clr", K_ERR, 0);
    expect_v("orph_data_clr", K_RAD, 0);
    cyc();

    // Port B shifter on a reserved write to r3
    rsv_en = 1; rsv_addr = 3; cyc();
    idle(); we = 1; wr_addr = 3; wr_data = 32'h8000_0010; cyc();
    idle(); rb_addr = 3;
    rb_mode = 2'b11; rb_shamt = 4;  expect_v("sra4", K_RBD, 32'hF800_0001); cyc();
    rb_mode = 2'b10; rb_shamt = 4;  expect_v("srl4", K_RBD, 32'h0800_0001); cyc();
    rb_mode = 2'b01; rb_shamt = 31; expect_v("sll31", K_RBD, 32'h0000_0000); cyc();
    rb_mode = 2'b00; rb_shamt = 7;  expect_v("pass", K_RBD, 32'h8000_0010); cyc();
    rb_mode = 2'b11; rb_shamt = 31; expect_v("sra31", K_RBD, 32'hFFFF_FFFF); cyc();
    rb_mode = 2'b10; rb_shamt = 31; expect_v("srl31", K_RBD, 32'h0000_0001); cyc();
    rb_mode = 2'b01; rb_shamt = 0;  expect_v("sll0", K_RBD, 32'h8000_0010); cyc();
    // Forwarded write feeds the shifter in the same cycle
    rsv_en = 1; rsv_addr = 4; cyc();
    idle(); we = 1; wr_addr = 4; wr_data = 32'h0000_00F1; rb_addr = 4;
    rb_mode = 2'b01; rb_shamt = 8;
    expect_v("fwd_sll8", K_RBD, 32'h0000_F100);
    expect_v("fwd_rbbusy", K_RBB, 0);
    cyc();
    idle();

    // Register 0 is hardwired: never written, never busy, never errors
    ra_addr = 0; rb_addr = 0; rb_mode = 2'b00;
    rsv_en = 1; rsv_addr = 0; we = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    expect_v("r0_fwd", K_RAD, 0);
    expect_v("r0_busy", K_RAB, 0);
    expect_v("r0_full", K_FULL, 0);
    cyc();
    idle();
    expect_v("r0_data", K_RAD, 0);
    expect_v("r0_rbdata", K_RBD, 0);
    expect_v("r0_busy2", K_RBB, 0);
    expect_v("r0_err", K_ERR, 0);
    cyc();

    // Write coincident with a reset edge is dropped
    reset = 1; we = 1; wr_addr = 10; wr_data = 32'h5555_AAAA;
    rsv_en = 1; rsv_addr = 10;
    cyc();
    idle(); ra_addr = 10;
    expect_v("rstwr_data", K_RAD, 0);
    expect_v("rstwr_busy", K_RAB, 0);
    expect_v("rstwr_err", K_ERR, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
